icache_data_port_ctrl: RTL and testbench
========================================

# icache_data_port_ctrl

Sequencer and arbiter for one way of the instruction-cache data RAM, a single-port 128 x 256-bit array with byte write enables and 1-cycle read latency. It shares the single RAM port between fetch-side line lookups and the refill path. It collects eight 32-bit refill beats into a line buffer and commits them to the RAM in one write cycle. It sits between the fetch pipeline and the per-way data RAM instance.

## Interface

Parameters:
- INDEX_W, 7, line index width (128 lines)
- LINE_W, 256, line width in bits
- BEAT_W, 32, refill beat width; LINE_W/BEAT_W = 8 beats

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- lookup_req  in  1  fetch requests a line read
- lookup_index  in  INDEX_W  line index to read
- lookup_ready  out  1  request accepted this cycle when high with lookup_req
- lookup_rvalid  out  1  read data valid
- lookup_rdata  out  LINE_W  line data
- refill_start  in  1  begin refill of refill_index
- refill_index  in  INDEX_W  target line, sampled with refill_start
- refill_beat_valid  in  1  beat present
- refill_beat_data  in  BEAT_W  beat payload
- refill_beat_last  in  1  final beat of burst
- refill_busy  out  1  refill in progress (COLLECT or WRITE)
- refill_done  out  1  one-cycle pulse after line is written
- ram_en  out  1  RAM enable
- ram_wen  out  LINE_W/8  byte write enables
- ram_index  out  INDEX_W  RAM address
- ram_wdata  out  LINE_W  RAM write data
- ram_rdata  in  LINE_W  RAM read data, valid 1 cycle after read

## Operation

- FSM states: IDLE, COLLECT, WRITE.
- IDLE -> COLLECT on refill_start. This latches refill_index into r_index, clears beat_cnt (3 bits), and clears the valid-word mask (8 bits).
- COLLECT: on each refill_beat_valid, the beat is written to buffer word beat_cnt (word 0 = bits 31:0), the mask bit is set, and beat_cnt increments.
- COLLECT -> WRITE when the accepted beat has refill_beat_last = 1, or when it is the 8th beat (beat_cnt == 7).
- Beats arriving outside COLLECT are ignored.
- refill_start outside IDLE is ignored.
- WRITE (exactly one cycle):
  - ram_en = 1, ram_index = r_index, ram_wdata = buffer.
  - ram_wen = each mask bit replicated x4; a short burst writes only the received words.
  - Next state is IDLE, with refill_done = 1 in that following cycle.
- Lookup path: when lookup_req && lookup_ready, drive ram_en = 1, ram_wen = 0, ram_index = lookup_index in the same cycle.
- Arbitration: WRITE has priority.
  - lookup_ready = 0 in WRITE (unless bypass applies; see Configuration).
  - lookup_ready = 0 in COLLECT when lookup_index == r_index (stale-line hazard).
  - Otherwise lookup_ready = 1.
- With no accepted lookup and not in WRITE: ram_en = 0, ram_wen = 0.
- Reset, including mid-refill: state IDLE, buffer write abandoned, no RAM write issued.

## Timing

- Reset values of registered outputs: lookup_rvalid 0, refill_done 0, refill_busy 0.
- lookup_rdata is don't-care while lookup_rvalid = 0.
- Lookup accepted in cycle T: lookup_rvalid = 1 in T+1, with lookup_rdata = ram_rdata.
- Back-to-back lookups sustain one per cycle.
- Refill of 8 beats, one per cycle, first beat in cycle C:
  - WRITE in C+8.
  - refill_done in C+9.
  - refill_busy high from the cycle after refill_start through C+8.
- A lookup to r_index issued during the refill stalls until the IDLE cycle (C+9), then reads the new data in C+10.
- A beat and the last-beat condition in the same cycle: beat stored, then WRITE next cycle.

## Configuration

- ICACHE_DATA_BYPASS_EN defined:
  - In WRITE, a lookup with lookup_index == r_index is accepted (lookup_ready = 1).
  - It does not drive the RAM port.
  - lookup_rvalid is asserted next cycle, with lookup_rdata = buffer for mask-set words and 0 elsewhere.
  - Non-matching lookups in WRITE still stall.
- Undefined: lookup_ready = 0 for every lookup during WRITE.

## Test plan

- Reset mid-COLLECT after 3 beats -> no ram_en with nonzero ram_wen ever; state IDLE; lookup_ready = 1; refill_done never pulses.
- Lookup idx 5 with RAM returning 0xA5..A5 -> ram_en = 1, ram_wen = 0 in T; lookup_rvalid = 1 with 0xA5..A5 in T+1.
- Refill idx 9 with beats 0x11111111..0x88888888 -> single WRITE cycle, ram_wen = 0xFFFFFFFF, word k = beat k; refill_done one cycle later.
- Short burst of 3 beats (last on 3rd) -> ram_wen = 0x00000FFF; words 3-7 unchanged on later readback.
- Lookup idx 9 during a refill of idx 9 -> lookup_ready = 0 until the post-WRITE cycle; readback equals refilled data. Lookup idx 4 in the same window is served without stall.
- ICACHE_DATA_BYPASS_EN defined, lookup idx 9 in the WRITE cycle -> accepted; next cycle lookup_rvalid = 1 with buffer data. Undefined -> stalled one cycle.

Source files
------------

// File: rtl/icache_data_port_ctrl.sv
// Shares one icache data-way RAM port between fetch lookups (data 1 cycle after accept) and 8-beat refills committed in one write.
// Lookups stall during WRITE and on a same-line hit while collecting; ICACHE_DATA_BYPASS_EN forwards the line buffer during WRITE.
module icache_data_port_ctrl #(
  parameter int INDEX_W = 7,
  parameter int LINE_W  = 256,
  parameter int BEAT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_req,
  input  logic [INDEX_W-1:0]    lookup_index,
  output logic                  lookup_ready,
  output logic                  lookup_rvalid,
  output logic [LINE_W-1:0]     lookup_rdata,
  input  logic                  refill_start,
  input  logic [INDEX_W-1:0]    refill_index,
  input  logic                  refill_beat_valid,
  input  logic [BEAT_W-1:0]     refill_beat_data,
  input  logic                  refill_beat_last,
  output logic                  refill_busy,
  output logic                  refill_done,
  output logic                  ram_en,
  output logic [LINE_W/8-1:0]   ram_wen,
  output logic [INDEX_W-1:0]    ram_index,
  output logic [LINE_W-1:0]     ram_wdata,
  input  logic [LINE_W-1:0]     ram_rdata
);

  localparam int NBEATS     = LINE_W / BEAT_W;
  localparam int CNT_W      = $clog2(NBEATS);
  localparam int BEAT_BYTES = BEAT_W / 8;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_e;

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   r_index_q, r_index_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NBEATS-1:0]    mask_q, mask_d;
  logic [LINE_W-1:0]    buf_q, buf_d;
  logic                 lookup_rvalid_q, lookup_rvalid_d;
  logic                 refill_done_q, refill_done_d;
  logic                 refill_busy_q, refill_busy_d;
  logic                 line_hit;
  logic                 lookup_fire;
`ifdef ICACHE_DATA_BYPASS_EN
  logic                 bypass_q, bypass_d;
`endif

  always_comb begin
    state_d    = state_q;
    r_index_d  = r_index_q;
    beat_cnt_d = beat_cnt_q;
    mask_d     = mask_q;
    buf_d      = buf_q;
    unique case (state_q)
      IDLE: begin
        if (refill_start) begin
          state_d    = COLLECT;
          r_index_d  = refill_index;
          beat_cnt_d = '0;
          mask_d     = '0;
        end
      end
      COLLECT: begin
        if (refill_beat_valid) begin
          buf_d[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = refill_beat_data;
          mask_d[beat_cnt_q] = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (refill_beat_last || (beat_cnt_q == CNT_W'(NBEATS-1))) begin
            state_d = WRITE;
          end
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Refill write owns the port; a lookup to the line being refilled would read stale data.
  always_comb begin
    line_hit     = (lookup_index == r_index_q);
    lookup_ready = 1'b1;
    unique case (state_q)
      COLLECT: lookup_ready = !line_hit;
`ifdef ICACHE_DATA_BYPASS_EN
      WRITE:   lookup_ready = line_hit;
`else
      WRITE:   lookup_ready = 1'b0;
`endif
      default: lookup_ready = 1'b1;
    endcase
    lookup_fire = lookup_req && lookup_ready;
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = '0;
    ram_index = lookup_index;
    ram_wdata = buf_q;
    if (state_q == WRITE) begin
      ram_en    = 1'b1;
      ram_index = r_index_q;
      for (int k = 0; k < NBEATS; k++) begin
        ram_wen[k*BEAT_BYTES +: BEAT_BYTES] = {BEAT_BYTES{mask_q[k]}};
      end
    end else if (lookup_fire) begin
      ram_en = 1'b1;
    end
  end

  always_comb begin
    lookup_rvalid_d = lookup_fire;
    refill_done_d   = (state_q == WRITE);
    refill_busy_d   = (state_d != IDLE);
`ifdef ICACHE_DATA_BYPASS_EN
    bypass_d        = lookup_fire && (state_q == WRITE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      r_index_q       <= '0;
      beat_cnt_q      <= '0;
      mask_q          <= '0;
      buf_q           <= '0;
      lookup_rvalid_q <= 1'b0;
      refill_done_q   <= 1'b0;
      refill_busy_q   <= 1'b0;
`ifdef ICACHE_DATA_BYPASS_EN
      bypass_q        <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      r_index_q       <= r_index_d;
      beat_cnt_q      <= beat_cnt_d;
      mask_q          <= mask_d;
      buf_q           <= buf_d;
      lookup_rvalid_q <= lookup_rvalid_d;
      refill_done_q   <= refill_done_d;
      refill_busy_q   <= refill_busy_d;
`ifdef ICACHE_DATA_BYPASS_EN
      bypass_q        <= bypass_d;
`endif
    end
  end

  assign lookup_rvalid = lookup_rvalid_q;
  assign refill_done   = refill_done_q;
  assign refill_busy   = refill_busy_q;

`ifdef ICACHE_DATA_BYPASS_EN
  // Buffer and mask stay intact through the cycle after WRITE, so forwarding reads them directly.
  always_comb begin
    lookup_rdata = ram_rdata;
    if (bypass_q) begin
      for (int k = 0; k < NBEATS; k++) begin
        lookup_rdata[k*BEAT_W +: BEAT_W] = mask_q[k] ? buf_q[k*BEAT_W +: BEAT_W] : '0;
      end
    end
  end
`else
  assign lookup_rdata = ram_rdata;
`endif

endmodule

// File: tb/tb_icache_data_port_ctrl.sv
// Directed bench for icache_data_port_ctrl with a behavioural 128 x 256 byte-enabled RAM.
module tb_icache_data_port_ctrl;

  logic         clk;
  logic         rst;
  logic         lookup_req;
  logic [6:0]   lookup_index;
  logic         lookup_ready;
  logic         lookup_rvalid;
  logic [255:0] lookup_rdata;
  logic         refill_start;
  logic [6:0]   refill_index;
  logic         refill_beat_valid;
  logic [31:0]  refill_beat_data;
  logic         refill_beat_last;
  logic         refill_busy;
  logic         refill_done;
  logic         ram_en;
  logic [31:0]  ram_wen;
  logic [6:0]   ram_index;
  logic [255:0] ram_wdata;
  logic [255:0] ram_rdata;

  logic [255:0] mem [128];
  logic [255:0] line_full;
  logic [255:0] line_short;
  int vectors;
  int miscompares;

  icache_data_port_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .lookup_req        (lookup_req),
    .lookup_index      (lookup_index),
    .lookup_ready      (lookup_ready),
    .lookup_rvalid     (lookup_rvalid),
    .lookup_rdata      (lookup_rdata),
    .refill_start      (refill_start),
    .refill_index      (refill_index),
    .refill_beat_valid (refill_beat_valid),
    .refill_beat_data  (refill_beat_data),
    .refill_beat_last  (refill_beat_last),
    .refill_busy       (refill_busy),
    .refill_done       (refill_done),
    .ram_en            (ram_en),
    .ram_wen           (ram_wen),
    .ram_index         (ram_index),
    .ram_wdata         (ram_wdata),
    .ram_rdata         (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen == 32'h0) begin
        ram_rdata <= mem[ram_index];
      end else begin
        for (int b = 0; b < 32; b++) begin
          if (ram_wen[b]) mem[ram_index][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
      end
    end
  end

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 128; i++) mem[i] = {32{8'(i)}};
    mem[5] = {32{8'hA5}};
    for (int k = 0; k < 8; k++) line_full[k*32 +: 32] = 32'h11111111 * (k + 1);
    line_short = {{5{32'hA5A5A5A5}}, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};

    rst = 1'b1;
    lookup_req = 1'b0; lookup_index = '0;
    refill_start = 1'b0; refill_index = '0;
    refill_beat_valid = 1'b0; refill_beat_data = '0; refill_beat_last = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chkn("rst_rvalid", 32'(lookup_rvalid), 0);
    chkn("rst_done", 32'(refill_done), 0);
    chkn("rst_busy", 32'(refill_busy), 0);
    chkn("rst_ram_en", 32'(ram_en), 0);
    @(negedge clk); rst = 1'b0;

    // Plain lookup of index 5
    @(negedge clk); lookup_req = 1'b1; lookup_index = 7'd5;
    #1;
    chkn("lk5_ready", 32'(lookup_ready), 1);
    chkn("lk5_ram_en", 32'(ram_en), 1);
    chkn("lk5_ram_wen", ram_wen, 0);
    chkn("lk5_ram_index", 32'(ram_index), 5);
    @(negedge clk); lookup_req = 1'b0;
    #1;
    chkn("lk5_rvalid", 32'(lookup_rvalid), 1);
    chk("lk5_rdata", lookup_rdata, {32{8'hA5}});
    chkn("lk5_idle_ram_en", 32'(ram_en), 0);
    @(negedge clk);
    #1;
    chkn("lk5_rvalid_drop", 32'(lookup_rvalid), 0);

    // Full 8-beat refill of index 9, hazard lookup 9 and free lookup 4 mid-burst
    @(negedge clk); refill_start = 1'b1; refill_index = 7'd9;
    #1;
    chkn("rf9_busy_start", 32'(refill_busy), 0);
    @(negedge clk); refill_start = 1'b0;
    #1;
    chkn("rf9_busy_collect", 32'(refill_busy), 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      refill_beat_valid = 1'b1;
      refill_beat_data = 32'h11111111 * (k + 1);
      lookup_req = (k == 2) || (k == 3);
      lookup_index = (k == 2) ? 7'd9 : 7'd4;
      #1;
      if (k == 2) begin
        chkn("haz9_ready", 32'(lookup_ready), 0);
        chkn("haz9_ram_en", 32'(ram_en), 0);
      end
      if (k == 3) begin
        chkn("lk4_ready", 32'(lookup_ready), 1);
        chkn("lk4_ram_en", 32'(ram_en), 1);
        chkn("lk4_ram_index", 32'(ram_index), 4);
        chkn("lk4_ram_wen", ram_wen, 0);
      end
      if (k == 4) begin
        chkn("lk4_rvalid", 32'(lookup_rvalid), 1);
        chk("lk4_rdata", lookup_rdata, {32{8'h04}});
      end
      chkn("rf9_busy_beat", 32'(refill_busy), 1);
    end
    @(negedge clk);
    refill_beat_valid = 1'b0;
    lookup_req = 1'b1; lookup_index = 7'd9;
    #1;
    chkn("wr9_ram_en", 32'(ram_en), 1);
    chkn("wr9_ram_wen", ram_wen, 32'hFFFF_FFFF);
    chkn("wr9_ram_index", 32'(ram_index), 9);
    chk("wr9_wdata", ram_wdata, line_full);
    chkn("wr9_busy", 32'(refill_busy), 1);
    chkn("wr9_done", 32'(refill_done), 0);
`ifdef ICACHE_DATA_BYPASS_EN
    chkn("wr9_bypass_ready", 32'(lookup_ready), 1);
`else
    chkn("wr9_stall_ready", 32'(lookup_ready), 0);
`endif
    @(negedge clk);
    #1;
    chkn("post9_done", 32'(refill_done), 1);
    chkn("post9_busy", 32'(refill_busy), 0);
    chkn("post9_ready", 32'(lookup_ready), 1);
    chkn("post9_ram_en", 32'(ram_en), 1);
    chkn("post9_ram_wen", ram_wen, 0);
    chkn("post9_ram_index", 32'(ram_index), 9);
`ifdef ICACHE_DATA_BYPASS_EN
    chkn("byp9_rvalid", 32'(lookup_rvalid), 1);
    chk("byp9_rdata", lookup_rdata, line_full);
`else
    chkn("stall9_rvalid", 32'(lookup_rvalid), 0);
`endif
    @(negedge clk); lookup_req = 1'b0;
    #1;
    chkn("rd9_rvalid", 32'(lookup_rvalid), 1);
    chk("rd9_rdata", lookup_rdata, line_full);
    chkn("rd9_done_pulse", 32'(refill_done), 0);

    // Short 3-beat refill of index 5; second refill_start mid-burst must be ignored
    @(negedge clk); refill_start = 1'b1; refill_index = 7'd5;
    @(negedge clk); refill_start = 1'b0;
    refill_beat_valid = 1'b1; refill_beat_data = 32'hC0DE0000;
    @(negedge clk); refill_start = 1'b1; refill_index = 7'd7;
    refill_beat_data = 32'hC0DE0001;
    @(negedge clk); refill_start = 1'b0;
    refill_beat_data = 32'hC0DE0002; refill_beat_last = 1'b1;
    @(negedge clk); refill_beat_valid = 1'b0; refill_beat_last = 1'b0;
    #1;
    chkn("sh5_ram_en", 32'(ram_en), 1);
    chkn("sh5_ram_wen", ram_wen, 32'h0000_0FFF);
    chkn("sh5_ram_index", 32'(ram_index), 5);
    chk("sh5_wdata_lo", {160'h0, ram_wdata[95:0]}, {160'h0, line_short[95:0]});
    @(negedge clk); lookup_req = 1'b1; lookup_index = 7'd5;
    #1;
    chkn("sh5_done", 32'(refill_done), 1);
    chkn("sh5_lk_ram_en", 32'(ram_en), 1);
    @(negedge clk); lookup_req = 1'b0;
    refill_beat_valid = 1'b1; refill_beat_data = 32'hFFFF_FFFF; refill_beat_last = 1'b1;
    #1;
    chkn("sh5_rvalid", 32'(lookup_rvalid), 1);
    chk("sh5_rdata", lookup_rdata, line_short);
    @(negedge clk); refill_beat_valid = 1'b0; refill_beat_last = 1'b0;
    #1;
    chkn("stray_beat_busy", 32'(refill_busy), 0);
    chkn("stray_beat_ram_en", 32'(ram_en), 0);

    // Reset in the middle of collecting a refill of index 12
    @(negedge clk); refill_start = 1'b1; refill_index = 7'd12;
    @(negedge clk); refill_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); refill_beat_valid = 1'b1; refill_beat_data = 32'hDEAD0000 + k;
    end
    @(negedge clk); refill_beat_valid = 1'b0; rst = 1'b1;
    #1;
    chkn("mid_rst_busy", 32'(refill_busy), 0);
    chkn("mid_rst_ram_en", 32'(ram_en), 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lookup_req = (i == 0);
      lookup_index = 7'd12;
      #1;
      if (i == 0) begin
        chkn("post_rst_ready", 32'(lookup_ready), 1);
        chkn("post_rst_ram_en", 32'(ram_en), 1);
      end
      if (i == 1) begin
        chkn("post_rst_rvalid", 32'(lookup_rvalid), 1);
        chk("post_rst_rdata", lookup_rdata, {32{8'h0C}});
      end
      chkn("post_rst_wen", ram_wen, 0);
      chkn("post_rst_done", 32'(refill_done), 0);
      chkn("post_rst_busy", 32'(refill_busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
